// File: rtl/axis_c2h_arbiter.sv
// axis_c2h_arbiter: packet-granular round-robin arbiter that shares one XDMA C2H
// AXI-Stream channel among NUM_SRC tlast-delimited packet sources.
// A grant is held for a whole packet and released after the tlast beat handshakes.
// While a packet is in flight the granted source passes straight through, with no added latency.
// Optional feature macro: C2H_ARB_PKT_CNT_EN adds per-source 32-bit packet counters (pkt_cnt).
module axis_c2h_arbiter #(
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned AXIS_DATA_WIDTH = 512,
    parameter int unsigned SRC_W           = 2
) (
    input  logic                                   m_axis_c2h_aclk,
    input  logic                                   m_axis_c2h_aresetn,
    input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_SRC*(AXIS_DATA_WIDTH/8)-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                     s_axis_tlast,
    input  logic [NUM_SRC-1:0]                     s_axis_tvalid,
    output logic [NUM_SRC-1:0]                     s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]             m_axis_c2h_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]           m_axis_c2h_tkeep,
    output logic                                   m_axis_c2h_tlast,
    output logic                                   m_axis_c2h_tvalid,
    input  logic                                   m_axis_c2h_tready,
    output logic [SRC_W-1:0]                       grant_id,
    output logic                                   busy
`ifdef C2H_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*32-1:0]                  pkt_cnt
`endif
);

    localparam int unsigned KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 32;
    localparam logic [SRC_W-1:0] RR_RST = SRC_W'(NUM_SRC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic             busy_q, busy_d;

    logic [SRC_W-1:0] sel_c;
    logic             req_found_c;
    logic             last_hs_c;

    // Round-robin search: first valid source starting just after the last owner
    always_comb begin
        logic [SRC_W-1:0] idx;
        sel_c       = '0;
        req_found_c = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = SRC_W'((32'(rr_q) + k) % NUM_SRC);
            if (!req_found_c && s_axis_tvalid[idx]) begin
                req_found_c = 1'b1;
                sel_c       = idx;
            end
        end
    end

    // Combinational pass-through of the granted source while a packet is in flight
    always_comb begin
        m_axis_c2h_tdata  = '0;
        m_axis_c2h_tkeep  = '0;
        m_axis_c2h_tlast  = 1'b0;
        m_axis_c2h_tvalid = 1'b0;
        s_axis_tready     = '0;
        if (state_q == XFER) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (grant_q == SRC_W'(i)) begin
                    m_axis_c2h_tdata  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                    m_axis_c2h_tkeep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                    m_axis_c2h_tlast  = s_axis_tlast[i];
                    m_axis_c2h_tvalid = s_axis_tvalid[i];
                    s_axis_tready[i]  = m_axis_c2h_tready;
                end
            end
        end
    end

    assign last_hs_c = m_axis_c2h_tvalid & m_axis_c2h_tready & m_axis_c2h_tlast;

    // Next-state logic: grant in IDLE, release after the tlast handshake
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (req_found_c) begin
                    state_d = XFER;
                    grant_d = sel_c;
                    rr_d    = sel_c;
                    busy_d  = 1'b1;
                end
            end
            XFER: begin
                if (last_hs_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and grant registers with synchronous active-low reset
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!m_axis_c2h_aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= RR_RST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

`ifdef C2H_ARB_PKT_CNT_EN
    logic [NUM_SRC*CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Per-source wrapping packet counters, bumped on each tlast handshake
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (last_hs_c) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (grant_q == SRC_W'(i)) begin
                    pkt_cnt_d[i*CNT_W +: CNT_W] = pkt_cnt_q[i*CNT_W +: CNT_W] + 32'd1;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (!m_axis_c2h_aresetn) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_c2h_arbiter.sv
// Directed self-checking bench for axis_c2h_arbiter (4 sources, 512-bit data).
module tb_axis_c2h_arbiter;

    localparam int NS = 4;
    localparam int DW = 512;
    localparam int KW = 64;

    logic              clk = 1'b0;
    logic              aresetn;
    logic [NS*DW-1:0]  s_tdata;
    logic [NS*KW-1:0]  s_tkeep;
    logic [NS-1:0]     s_tlast;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef C2H_ARB_PKT_CNT_EN
    logic [NS*32-1:0]  pkt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // source model state
    int left[NS];
    int len[NS];
    int sent[NS];
    int beat[NS];

    // observed master-side beats
    logic [DW-1:0] ob_data[$];
    logic [KW-1:0] ob_keep[$];
    logic          ob_last[$];
    int            ob_grant[$];
    int            ob_cyc[$];
    // per-cycle log
    logic          lg_busy[$];
    int            lg_grant[$];
    logic          lg_mready[$];
    logic [NS-1:0] lg_sready[$];

    axis_c2h_arbiter #(
        .NUM_SRC(NS),
        .AXIS_DATA_WIDTH(DW),
        .SRC_W(2)
    ) dut (
        .m_axis_c2h_aclk(clk),
        .m_axis_c2h_aresetn(aresetn),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_c2h_tdata(m_tdata),
        .m_axis_c2h_tkeep(m_tkeep),
        .m_axis_c2h_tlast(m_tlast),
        .m_axis_c2h_tvalid(m_tvalid),
        .m_axis_c2h_tready(m_tready),
        .grant_id(grant_id),
        .busy(busy)
`ifdef C2H_ARB_PKT_CNT_EN
        ,
        .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] make_data(input int src, input int pkt, input int b);
        logic [31:0] w;
        w = {8'hC2, 8'(src), 8'(pkt), 8'(b)};
        return {16{w}};
    endfunction

    function automatic logic [KW-1:0] make_keep(input int src, input logic last);
        logic [KW-1:0] k;
        k = '1;
        if (last) k = k >> (src + 1);
        return k;
    endfunction

    task automatic clear_src();
        for (int i = 0; i < NS; i++) begin
            left[i] = 0;
            len[i]  = 1;
            sent[i] = 0;
            beat[i] = 0;
        end
    endtask

    // Drive the source model cycle by cycle until every packet is consumed
    task automatic run_traffic(input int max_cycles, input bit rand_ready, output bit timed_out);
        int n;
        bit done;
        ob_data.delete(); ob_keep.delete(); ob_last.delete(); ob_grant.delete(); ob_cyc.delete();
        lg_busy.delete(); lg_grant.delete(); lg_mready.delete(); lg_sready.delete();
        n = 0;
        done = 1'b0;
        timed_out = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int i = 0; i < NS; i++) begin
                s_tvalid[i] = (left[i] > 0);
                s_tlast[i]  = (left[i] > 0) && (beat[i] == len[i] - 1);
                s_tdata[i*DW +: DW] = make_data(i, sent[i], beat[i]);
                s_tkeep[i*KW +: KW] = make_keep(i, s_tlast[i]);
            end
            #1;
            lg_busy.push_back(busy);
            lg_grant.push_back(int'(grant_id));
            lg_mready.push_back(m_tready);
            lg_sready.push_back(s_tready);
            if (m_tvalid && m_tready) begin
                ob_data.push_back(m_tdata);
                ob_keep.push_back(m_tkeep);
                ob_last.push_back(m_tlast);
                ob_grant.push_back(int'(grant_id));
                ob_cyc.push_back(n);
            end
            for (int i = 0; i < NS; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    if (s_tlast[i]) begin
                        beat[i] = 0;
                        sent[i]++;
                        left[i]--;
                    end else begin
                        beat[i]++;
                    end
                end
            end
            n++;
            done = 1'b1;
            for (int i = 0; i < NS; i++) if (left[i] > 0) done = 1'b0;
            if (!done && n >= max_cycles) begin
                timed_out = 1'b1;
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
    endtask

    task automatic test_reset();
        aresetn  = 1'b0;
        s_tvalid = '1;
        s_tlast  = '1;
        m_tready = 1'b1;
        repeat (4) begin
            @(posedge clk); #2;
            checks++;
            if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
            checks++;
            if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready got=%b exp=0000", s_tready); end
            checks++;
            if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        end
        s_tvalid = '0;
        s_tlast  = '0;
        @(posedge clk); #1;
        aresetn = 1'b1;
    endtask

    task automatic test_round_robin();
        bit to;
        int p, exp_gap;
        clear_src();
        for (int i = 0; i < NS; i++) begin left[i] = 3; len[i] = 4; end
        run_traffic(200, 1'b0, to);
        checks++;
        if (to) begin errors++; $display("FAIL rr_timeout got=timeout exp=done"); end
        checks++;
        if (ob_data.size() != 48) begin errors++; $display("FAIL rr_beats got=%0d exp=48", ob_data.size()); end
        for (int k = 0; k < ob_data.size() && k < 48; k++) begin
            p = k / 4;
            checks++;
            if (ob_data[k] !== make_data(p % 4, p / 4, k % 4)) begin
                errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, ob_data[k][31:0], make_data(p % 4, p / 4, k % 4) & 512'hFFFFFFFF);
            end
            checks++;
            if (ob_grant[k] != p % 4 || ob_last[k] !== (k % 4 == 3) || ob_keep[k] !== make_keep(p % 4, k % 4 == 3)) begin
                errors++; $display("FAIL rr_ctl[%0d] got grant=%0d last=%b exp grant=%0d last=%b", k, ob_grant[k], ob_last[k], p % 4, k % 4 == 3);
            end
            if (k > 0) begin
                exp_gap = (k % 4 == 0) ? 2 : 1;
                checks++;
                if (ob_cyc[k] - ob_cyc[k-1] != exp_gap) begin
                    errors++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", k, ob_cyc[k] - ob_cyc[k-1], exp_gap);
                end
            end
        end
    endtask

    task automatic test_single();
        bit to;
        clear_src();
        left[2] = 5;
        len[2]  = 1;
        run_traffic(60, 1'b0, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout got=timeout exp=done"); end
        checks++;
        if (ob_data.size() != 5) begin errors++; $display("FAIL single_beats got=%0d exp=5", ob_data.size()); end
        for (int k = 0; k < ob_data.size() && k < 5; k++) begin
            checks++;
            if (ob_grant[k] != 2 || ob_last[k] !== 1'b1 || ob_data[k] !== make_data(2, k, 0) || ob_keep[k] !== make_keep(2, 1'b1)) begin
                errors++; $display("FAIL single_beat[%0d] got grant=%0d last=%b exp grant=2 last=1", k, ob_grant[k], ob_last[k]);
            end
            if (k > 0) begin
                checks++;
                if (ob_cyc[k] - ob_cyc[k-1] != 2) begin
                    errors++; $display("FAIL single_gap[%0d] got=%0d exp=2", k, ob_cyc[k] - ob_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int es[13];
        int ep[13];
        int eb[13];
        int el[13];
        int n;
        logic [NS-1:0] exp_rdy;
        clear_src();
        left[0] = 1; len[0] = 3;
        left[1] = 2; len[1] = 5;
        // rr points at src2 after the previous test: src0 first, then src1 twice
        n = 0;
        for (int b = 0; b < 3; b++) begin es[n] = 0; ep[n] = 0; eb[n] = b; el[n] = (b == 2); n++; end
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 5; b++) begin es[n] = 1; ep[n] = p; eb[n] = b; el[n] = (b == 4); n++; end
        run_traffic(300, 1'b1, to);
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout got=timeout exp=done"); end
        checks++;
        if (ob_data.size() != 13) begin errors++; $display("FAIL bp_beats got=%0d exp=13", ob_data.size()); end
        for (int k = 0; k < ob_data.size() && k < 13; k++) begin
            checks++;
            if (ob_data[k] !== make_data(es[k], ep[k], eb[k]) || ob_grant[k] != es[k] || ob_last[k] !== 1'(el[k])) begin
                errors++; $display("FAIL bp_beat[%0d] got grant=%0d w=%h exp grant=%0d w=%h", k, ob_grant[k], ob_data[k][31:0], es[k], make_data(es[k], ep[k], eb[k]) & 512'hFFFFFFFF);
            end
        end
        for (int j = 0; j < lg_busy.size(); j++) begin
            if (lg_busy[j] && lg_grant[j] == 1) begin
                exp_rdy = {2'b00, lg_mready[j], 1'b0};
                checks++;
                if (lg_sready[j] !== exp_rdy) begin
                    errors++; $display("FAIL bp_mirror[%0d] got=%b exp=%b", j, lg_sready[j], exp_rdy);
                end
            end
            if (j > 0 && lg_busy[j] && lg_busy[j-1]) begin
                checks++;
                if (lg_grant[j] != lg_grant[j-1]) begin
                    errors++; $display("FAIL bp_hold[%0d] got=%0d exp=%0d", j, lg_grant[j], lg_grant[j-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 4'b1000;
        s_tlast  = '0;
        s_tdata[3*DW +: DW] = make_data(3, 0, 0);
        @(posedge clk); #2;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd3 || m_tdata !== make_data(3, 0, 0)) begin
            errors++; $display("FAIL mid_grant got busy=%b grant=%0d exp busy=1 grant=3", busy, grant_id);
        end
        @(posedge clk); #1;
        s_tdata[3*DW +: DW] = make_data(3, 0, 1);
        @(posedge clk); #1;
        s_tdata[3*DW +: DW] = make_data(3, 0, 2);
        #1;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== make_data(3, 0, 2)) begin
            errors++; $display("FAIL mid_beat2 got valid=%b w=%h exp valid=1 w=c2030002", m_tvalid, m_tdata[31:0]);
        end
        aresetn  = 1'b0;
        s_tvalid = 4'b1001;
        s_tdata[0 +: DW] = make_data(0, 0, 0);
        s_tlast[0] = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0000 || grant_id !== 2'd0) begin
            errors++; $display("FAIL mid_reset got valid=%b busy=%b rdy=%b grant=%0d exp 0 0 0000 0", m_tvalid, busy, s_tready, grant_id);
        end
        aresetn = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (grant_id !== 2'd0 || busy !== 1'b1 || m_tdata !== make_data(0, 0, 0)) begin
            errors++; $display("FAIL mid_regrant got grant=%0d busy=%b exp grant=0 busy=1", grant_id, busy);
        end
        s_tvalid = '0;
        s_tlast  = '0;
        aresetn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

`ifdef C2H_ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        bit to;
        logic [31:0] exp_cnt[3];
        exp_cnt[0] = 32'hFFFF_FFFF;
        exp_cnt[1] = 32'h0000_0000;
        exp_cnt[2] = 32'h0000_0001;
        @(posedge clk); #1;
        force dut.pkt_cnt_q = {96'd0, 32'hFFFF_FFFE};
        @(posedge clk); #1;
        release dut.pkt_cnt_q;
        #1;
        checks++;
        if (pkt_cnt[31:0] !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL cnt_preload got=%h exp=fffffffe", pkt_cnt[31:0]);
        end
        for (int p = 0; p < 3; p++) begin
            clear_src();
            left[0] = 1;
            len[0]  = 1;
            run_traffic(20, 1'b0, to);
            checks++;
            if (to || pkt_cnt[31:0] !== exp_cnt[p]) begin
                errors++; $display("FAIL cnt_src0[%0d] got=%h exp=%h", p, pkt_cnt[31:0], exp_cnt[p]);
            end
        end
        checks++;
        if (pkt_cnt[127:32] !== 96'd0) begin
            errors++; $display("FAIL cnt_others got=%h exp=0", pkt_cnt[127:32]);
        end
    endtask
`endif

    initial begin
        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        m_tready = 1'b1;
        clear_src();
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_reset_mid();
`ifdef C2H_ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
